// File: rtl/soda_machine_controller_if.sv
// Handshake bundle between soda_machine_controller (master) and the purchase datapath (slave).
// Buttons and datapath status flow into the controller; enables and display control flow out.
interface soda_machine_controller_if;
   logic       btn_sel;
   logic       btn_done;
   logic       btn_coin;
   logic       btn_cancel;
   logic [7:0] cost_in;
   logic [7:0] total_in;
   logic       cost_add;
   logic       cost;
   logic       coins;
   logic       coins_add;
   logic       c_wrap;
   logic       start_disp;
   logic [2:0] disp_data;
   logic       dispenced;
   logic       dp_clr_n;
   logic       busy;

   modport master (
      input  btn_sel, btn_done, btn_coin, btn_cancel, cost_in, total_in,
      output cost_add, cost, coins, coins_add, c_wrap, start_disp, disp_data,
             dispenced, dp_clr_n, busy
   );

   modport slave (
      output btn_sel, btn_done, btn_coin, btn_cancel, cost_in, total_in,
      input  cost_add, cost, coins, coins_add, c_wrap, start_disp, disp_data,
             dispenced, dp_clr_n, busy
   );
endinterface

// File: rtl/soda_machine_controller.sv
// Moore FSM sequencing the soda machine datapath: cost entry, coin entry, compare, dispense, clear.
// Optional macro COIN_TIMEOUT_EN aborts a purchase after COIN_TIMEOUT idle cycles in WAIT_COIN.
module soda_machine_controller #(
   parameter int unsigned SHOW_CYCLES  = 2,
   parameter int unsigned DISP_HOLD    = 4,
   parameter int unsigned MAX_ITEMS    = 7,
   parameter int unsigned COIN_TIMEOUT = 40
) (
   input logic                       clk,
   input logic                       nrst,
   soda_machine_controller_if.master sm
);
   typedef enum logic [3:0] {
      S_IDLE, S_ADD, S_ENTRY, S_LATCH, S_SHOW_COST, S_WAIT_COIN, S_COIN_LAT,
      S_COIN_ADD, S_SHOW_COIN, S_SHOW_TOT, S_CHECK, S_DISPENSE, S_CLEAR
   } state_t;

   localparam logic [7:0] SHOW_LAST = 8'(SHOW_CYCLES - 1);
   localparam logic [7:0] DISP_LAST = 8'(DISP_HOLD - 1);
   localparam logic [7:0] ITEM_MAX  = 8'(MAX_ITEMS);

   if (SHOW_CYCLES == 0 || SHOW_CYCLES > 256 || DISP_HOLD == 0 || DISP_HOLD > 256 ||
       MAX_ITEMS > 255 || COIN_TIMEOUT == 0 || COIN_TIMEOUT > 256) begin : g_bad_params
      $error("soda_machine_controller: parameter out of 8-bit counter range");
   end

   state_t     state_q, state_d;
   logic [7:0] timer_q, timer_d;
   logic [7:0] item_cnt_q, item_cnt_d;
   logic       cancel, timeout, timer_show_done, timer_disp_done;

   logic       cost_add_q, cost_add_d, cost_q, cost_d, coins_q, coins_d;
   logic       coins_add_q, coins_add_d, c_wrap_q, c_wrap_d, start_disp_q, start_disp_d;
   logic       dispenced_q, dispenced_d, dp_clr_n_q, dp_clr_n_d, busy_q, busy_d;
   logic [2:0] disp_q, disp_d;

`ifdef COIN_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(COIN_TIMEOUT - 1);
   logic [7:0] to_q, to_d;

   always_comb to_d = (state_q == S_WAIT_COIN && !sm.btn_coin) ? to_q + 8'd1 : '0;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) to_q <= '0;
      else       to_q <= to_d;
   end

   assign timeout = (to_q == TO_LAST);
`else
   assign timeout = 1'b0;
`endif

   assign timer_show_done = (timer_q == SHOW_LAST);
   assign timer_disp_done = (timer_q == DISP_LAST);
   assign cancel = sm.btn_cancel && !(state_q inside {S_IDLE, S_DISPENSE, S_CLEAR});

   always_comb begin
      state_d    = state_q;
      item_cnt_d = item_cnt_q;
      timer_d    = '0;
      case (state_q)
         S_IDLE:      if (sm.btn_sel) state_d = S_ADD;
         S_ADD:       state_d = S_ENTRY;
         S_ENTRY: begin
            if (sm.btn_done)                             state_d = S_LATCH;
            else if (sm.btn_sel && item_cnt_q < ITEM_MAX) state_d = S_ADD;
         end
         S_LATCH:     state_d = S_SHOW_COST;
         S_SHOW_COST: if (timer_show_done) state_d = (sm.cost_in == '0) ? S_CLEAR : S_WAIT_COIN;
         S_WAIT_COIN: begin
            if (sm.btn_coin)  state_d = S_COIN_LAT;
            else if (timeout) state_d = S_CLEAR;
         end
         S_COIN_LAT:  state_d = S_COIN_ADD;
         S_COIN_ADD:  state_d = S_SHOW_COIN;
         S_SHOW_COIN: if (timer_show_done) state_d = S_SHOW_TOT;
         S_SHOW_TOT:  if (timer_show_done) state_d = S_CHECK;
         S_CHECK:     state_d = (sm.total_in >= sm.cost_in) ? S_DISPENSE : S_WAIT_COIN;
         S_DISPENSE:  if (timer_disp_done) state_d = S_CLEAR;
         S_CLEAR:     state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
      if (cancel) state_d = S_CLEAR;

      if (state_d == state_q &&
          state_q inside {S_SHOW_COST, S_SHOW_COIN, S_SHOW_TOT, S_DISPENSE})
         timer_d = timer_q + 8'd1;
      if (state_d == S_ADD)   item_cnt_d = item_cnt_q + 8'd1;
      if (state_d == S_CLEAR) item_cnt_d = '0;
   end

   // Outputs decode the next state so they appear registered in the cycle the state is entered.
   always_comb begin
      cost_add_d  = (state_d == S_ADD);
      cost_d      = (state_d == S_LATCH);
      coins_d     = (state_d == S_COIN_LAT);
      coins_add_d = (state_d == S_COIN_ADD);
      dispenced_d = (state_d == S_DISPENSE);
      dp_clr_n_d  = (state_d != S_CLEAR);
      busy_d      = (state_d != S_IDLE);
      c_wrap_d    = 1'b0;
      if (state_d == S_DISPENSE)
         c_wrap_d = (state_q == S_CHECK) ? (sm.total_in > sm.cost_in) : c_wrap_q;
      // Non-display states keep the last screen so the OLED is not refreshed needlessly.
      disp_d = disp_q;
      case (state_d)
         S_IDLE:      disp_d = 3'b000;
         S_SHOW_COST: disp_d = 3'b010;
         S_SHOW_COIN: disp_d = 3'b011;
         S_SHOW_TOT:  disp_d = 3'b100;
         S_DISPENSE:  disp_d = 3'b101;
         S_CLEAR:     disp_d = 3'b110;
         default:     disp_d = disp_q;
      endcase
      start_disp_d = (disp_d != disp_q);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q      <= S_IDLE;
         timer_q      <= '0;
         item_cnt_q   <= '0;
         cost_add_q   <= 1'b0;
         cost_q       <= 1'b0;
         coins_q      <= 1'b0;
         coins_add_q  <= 1'b0;
         c_wrap_q     <= 1'b0;
         start_disp_q <= 1'b0;
         disp_q       <= '0;
         dispenced_q  <= 1'b0;
         dp_clr_n_q   <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         item_cnt_q   <= item_cnt_d;
         cost_add_q   <= cost_add_d;
         cost_q       <= cost_d;
         coins_q      <= coins_d;
         coins_add_q  <= coins_add_d;
         c_wrap_q     <= c_wrap_d;
         start_disp_q <= start_disp_d;
         disp_q       <= disp_d;
         dispenced_q  <= dispenced_d;
         dp_clr_n_q   <= dp_clr_n_d;
         busy_q       <= busy_d;
      end
   end

   assign sm.cost_add   = cost_add_q;
   assign sm.cost       = cost_q;
   assign sm.coins      = coins_q;
   assign sm.coins_add  = coins_add_q;
   assign sm.c_wrap     = c_wrap_q;
   assign sm.start_disp = start_disp_q;
   assign sm.disp_data  = disp_q;
   assign sm.dispenced  = dispenced_q;
   assign sm.dp_clr_n   = dp_clr_n_q;
   assign sm.busy       = busy_q;
endmodule

// File: doc/soda_machine_controller.md
Name: soda_machine_controller

Overview:
Moore FSM that sequences soda_machine_wrapper_datapath through a purchase: cost entry, coin entry, comparison, dispense, clear.
- Generates the datapath register enables (cost_add, cost, coins, coins_add), the change flag (c_wrap), the OLED selector (disp_data), display-start pulses, and a datapath clear.
- Runs on the same slow clock the datapath registers use (the 2 Hz domain at top level).
- Button inputs are debounced single-cycle pulses in this clock domain.

Parameters:
SHOW_CYCLES, 2, cycles each informational screen (cost/coins/total) is held before the FSM proceeds
DISP_HOLD, 4, cycles dispensed is held high
MAX_ITEMS, 7, max cost_add accumulations per purchase; extra btn_sel pulses are ignored
COIN_TIMEOUT, 40, idle cycles in WAIT_COIN before abort (only with COIN_TIMEOUT_EN)

Ports:
clk  in  1  controller clock; same edge as datapath registers
nrst  in  1  asynchronous active-low reset
btn_sel  in  1  pulse: add current switch price to cost
btn_done  in  1  pulse: cost entry finished
btn_coin  in  1  pulse: latch current switch value as an inserted coin
btn_cancel  in  1  pulse: abort purchase
cost_in  in  8  datapath final_cost
total_in  in  8  datapath running coin total
cost_add  out  1  enable for cost accumulator register
cost  out  1  enable for final cost register
coins  out  1  enable for detected-coin register
coins_add  out  1  enable for coin total register
c_wrap  out  1  change-due flag to datapath c_reg
start_disp  out  1  one-cycle OLED refresh request
disp_data  out  3  screen select: 000 idle, 010 cost, 011 coin, 100 total, 101 dispensed, 110 blank
dispenced  out  1  product dispensed
dp_clr_n  out  1  active-low datapath clear; ANDed with nrst at top level
busy  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered. Reset values: every output 0, except dp_clr_n=1. State resets to IDLE and counters reset to 0.
- The transition into a state drives that state's outputs in the following cycle.
- start_disp pulses for exactly 1 cycle whenever disp_data takes a new value, in the same cycle as the new value.
- States and transitions:
  - IDLE: disp_data=000. btn_sel -> ADD.
  - ADD: cost_add=1 for 1 cycle; item_cnt++ -> ENTRY.
  - ENTRY: btn_sel with item_cnt<MAX_ITEMS -> ADD. btn_done -> LATCH.
  - LATCH: cost=1 for 1 cycle -> SHOW_COST.
  - SHOW_COST: disp_data=010 for SHOW_CYCLES. Then, if cost_in==0 -> CLEAR, else -> WAIT_COIN.
  - WAIT_COIN: btn_coin -> COIN_LAT.
  - COIN_LAT: coins=1 for 1 cycle -> COIN_ADD.
  - COIN_ADD: coins_add=1 for 1 cycle -> SHOW_COIN.
  - SHOW_COIN: disp_data=011 for SHOW_CYCLES -> SHOW_TOT.
  - SHOW_TOT: disp_data=100 for SHOW_CYCLES -> CHECK.
  - CHECK: single cycle; samples total_in and cost_in. total_in>=cost_in -> DISPENSE, else -> WAIT_COIN.
  - DISPENSE: dispenced=1 and disp_data=101 for DISP_HOLD cycles. c_wrap=1 for the whole state if total_in>cost_in (strictly greater), else 0 -> CLEAR.
  - CLEAR: dp_clr_n=0 and disp_data=110 for 1 cycle; item_cnt cleared; c_wrap returns to 0 -> IDLE.
- btn_cancel in any state other than IDLE, DISPENSE or CLEAR -> CLEAR. Cancel wins over any simultaneous button. Cancel is ignored during DISPENSE.
- Buttons arriving in states that do not consume them are dropped, not queued.
- btn_sel and btn_done in the same cycle in ENTRY: btn_done wins and the selection is dropped.
- Comparisons are 8-bit unsigned. Datapath overflow wrap is not detected.
- nrst asserted mid-purchase: immediate return to IDLE with all outputs at reset values.

Optional Feature:
COIN_TIMEOUT_EN
- Defined: an 8-bit counter runs in WAIT_COIN and clears on btn_coin. When it reaches COIN_TIMEOUT -> CLEAR. Total paid is lost and dispenced stays 0.
- Undefined: no counter; WAIT_COIN waits indefinitely.

Test Plan:
- nrst low mid-DISPENSE -> all outputs 0, dp_clr_n=1, busy=0 immediately (asynchronously); next btn_sel starts a fresh purchase.
- Switches=100, btn_sel; switches=010, btn_sel; btn_done -> 2 cost_add pulses, 1 cost pulse, disp_data=010 with start_disp, cost_in=35 (0x23).
- Cost 35; coin switches=100 then 010 -> after first coin, CHECK returns to WAIT_COIN with total 25. After second coin, total 35 -> dispenced high 4 cycles, c_wrap=0, then dp_clr_n low 1 cycle.
- Cost 35; single coin switches=111 (40) -> DISPENSE with c_wrap=1 for 4 cycles, disp_data=101.
- btn_sel pressed 9 times -> exactly 7 cost_add pulses. btn_done with switches=000 (cost 0) -> SHOW_COST then CLEAR; no dispense.
- btn_cancel together with btn_coin in WAIT_COIN -> CLEAR, no coins pulse. With COIN_TIMEOUT_EN defined, 40 cycles idle in WAIT_COIN -> CLEAR, dispenced=0.
